alien_depth_sorter: RTL

Upstream stage of the per-quadrant VGA output interface. Once per frame it snapshots the alien record array from the game core and reorders it by the key (distance `_r` ascending, original index ascending), with inactive records placed last. It publishes the sorted array atomically, so the renderer's first-match priority scan always selects the closest alien. The sort is a sequential 16-bucket counting sort with a start/done handshake, and completes well inside one VGA line.

---
 rtl/alien_depth_sorter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/alien_depth_sorter.sv
// Snapshots the alien record array and counting-sorts it by (_r, index), inactive last,
// publishing the result atomically. Optional macro: ALIEN_SORT_QUADRANT_FILTER_EN.
module alien_depth_sorter #(
    parameter int OBJ_LIMIT = 16,
    parameter int REC_W     = 35,
    parameter int QUADRANT  = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [OBJ_LIMIT*REC_W-1:0]     obj_in,
    output logic                           busy,
    output logic                           done,
    output logic [OBJ_LIMIT*REC_W-1:0]     obj_out,
    output logic [$clog2(OBJ_LIMIT+1)-1:0] active_count
);

    localparam int CW        = $clog2(OBJ_LIMIT + 1);
    localparam int ACT_BIT   = 0;
    localparam int R_LSB     = 5;
    localparam int QUAD_LSB  = 9;
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] LIMIT_C = CW'(OBJ_LIMIT);
    localparam logic [1:0]    QUAD_C  = QUADRANT[1:0];
`ifdef ALIEN_SORT_QUADRANT_FILTER_EN
    localparam logic FILTER_C = 1'b1;
`else
    localparam logic FILTER_C = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FLUSH  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [OBJ_LIMIT*REC_W-1:0]   r_snap;
    logic [OBJ_LIMIT*REC_W-1:0]   r_work;
    logic [OBJ_LIMIT*REC_W-1:0]   w_work_nxt;
    logic [OBJ_LIMIT*REC_W-1:0]   r_obj_out;
    logic [CW-1:0]                r_wp;
    logic [CW-1:0]                w_wp_nxt;
    logic [CW-1:0]                w_cnt;
    logic [CW-1:0]                w_slot;
    logic [CW-1:0]                r_act_wp;
    logic [CW-1:0]                r_active_count;
    logic [3:0]                   r_bucket;
    logic                         r_busy;
    logic                         r_done;
    logic [OBJ_LIMIT-1:0]         w_match;
    logic                         w_load;
    logic                         w_step;
    logic                         w_commit;

    // A record is sortable when active and, with filtering, on this quadrant.
    function automatic logic is_active(input logic act, input logic [1:0] quad);
        return act && (!FILTER_C || (quad == QUAD_C));
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = SCAN; else w_state_nxt = IDLE;
            SCAN:    if (r_bucket == 4'd15) w_state_nxt = FLUSH; else w_state_nxt = SCAN;
            FLUSH:   w_state_nxt = COMMIT;
            COMMIT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath strobes decoded from the current state.
    always_comb begin
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            IDLE:    w_load   = start;
            SCAN:    w_step   = 1'b1;
            FLUSH:   w_step   = 1'b1;
            COMMIT:  w_commit = 1'b1;
            default: w_load   = 1'b0;
        endcase
    end

    // Match set: current bucket while scanning, everything not active while flushing.
    always_comb begin
        w_match = '0;
        for (int k = 0; k < OBJ_LIMIT; k++) begin
            case (r_state)
                SCAN:    w_match[k] = is_active(r_snap[k*REC_W + ACT_BIT], r_snap[k*REC_W + QUAD_LSB +: 2])
                                      && (r_snap[k*REC_W + R_LSB +: 4] == r_bucket);
                FLUSH:   w_match[k] = !is_active(r_snap[k*REC_W + ACT_BIT], r_snap[k*REC_W + QUAD_LSB +: 2]);
                default: w_match[k] = 1'b0;
            endcase
        end
    end

    // Compaction: matches land at wp plus the count of lower-index matches.
    always_comb begin
        w_work_nxt = r_work;
        w_cnt      = '0;
        w_slot     = '0;
        for (int k = 0; k < OBJ_LIMIT; k++) begin
            if (w_match[k]) begin
                w_slot = r_wp + w_cnt;
                if (w_slot < LIMIT_C) begin
                    w_work_nxt[int'(w_slot)*REC_W +: REC_W] = r_snap[k*REC_W +: REC_W];
                end else begin
                    w_work_nxt = w_work_nxt;
                end
                w_cnt = w_cnt + ONE_C;
            end else begin
                w_cnt = w_cnt;
            end
        end
        w_wp_nxt = r_wp + w_cnt;
    end

    // Snapshot, work buffer, pointers and published outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_snap         <= '0;
            r_work         <= '0;
            r_obj_out      <= '0;
            r_wp           <= '0;
            r_act_wp       <= '0;
            r_active_count <= '0;
            r_bucket       <= 4'd0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_snap   <= obj_in;
                r_work   <= '0;
                r_wp     <= '0;
                r_bucket <= 4'd0;
                r_busy   <= 1'b1;
            end else if (w_step) begin
                r_work   <= w_work_nxt;
                r_wp     <= w_wp_nxt;
                r_bucket <= r_bucket + 4'd1;
                // Captured on the FLUSH edge, before inactive records advance wp.
                if (r_state == FLUSH) r_act_wp <= r_wp; else r_act_wp <= r_act_wp;
            end else if (w_commit) begin
                r_obj_out      <= r_work;
                r_active_count <= r_act_wp;
                r_done         <= 1'b1;
                r_busy         <= 1'b0;
            end else begin
                r_busy <= r_busy;
            end
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign obj_out      = r_obj_out;
    assign active_count = r_active_count;

endmodule
